decode_stage: RTL

//  Parametrised RV32I decode stage with a registered ID/EX output.
//  - Splits instruction fields, generates I/S/B/U/J immediates and control signals.
//  - Holds the register file; reads rs1/rs2 into the output register.
//  - Sits between fetch (IF/ID) and execute; valid/ready handshake on both sides.
//  - flush_i poisons the held slot; illegal opcodes are flagged.

---
 rtl/decode_stage_if.sv | 56 +++++
 rtl/decode_stage.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side, writeback/flush and ID/EX-side signals of the decode stage.
interface decode_stage_if #(
    parameter int unsigned XLEN = 32
);
    // Fetch side (IF/ID)
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] pc_plus4_i;

    // Writeback and pipeline control
    logic            wb_we;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            flush_i;

    // Execute side (ID/EX slot)
    logic            out_valid;
    logic            out_ready;
    logic            reg_write_o;
    logic [1:0]      result_src_o;
    logic            mem_write_o;
    logic            jump_o;
    logic            branch_o;
    logic [3:0]      alu_ctrl_o;
    logic            alu_srca_o;
    logic            alu_src_o;
    logic [XLEN-1:0] rd1_o;
    logic [XLEN-1:0] rd2_o;
    logic [4:0]      rs1_o;
    logic [4:0]      rs2_o;
    logic [4:0]      rd_o;
    logic [XLEN-1:0] imm_o;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_plus4_o;
    logic            illegal_o;

    // Surroundings of the decode stage: fetch, writeback and execute
    modport master (
        output in_valid, instr_i, pc_i, pc_plus4_i,
        output wb_we, wb_rd, wb_data, flush_i, out_ready,
        input  in_ready, out_valid, reg_write_o, result_src_o, mem_write_o,
        input  jump_o, branch_o, alu_ctrl_o, alu_srca_o, alu_src_o,
        input  rd1_o, rd2_o, rs1_o, rs2_o, rd_o, imm_o, pc_o, pc_plus4_o, illegal_o
    );

    // The decode stage itself
    modport slave (
        input  in_valid, instr_i, pc_i, pc_plus4_i,
        input  wb_we, wb_rd, wb_data, flush_i, out_ready,
        output in_ready, out_valid, reg_write_o, result_src_o, mem_write_o,
        output jump_o, branch_o, alu_ctrl_o, alu_srca_o, alu_src_o,
        output rd1_o, rd2_o, rs1_o, rs2_o, rd_o, imm_o, pc_o, pc_plus4_o, illegal_o
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I decode with register file and a registered ID/EX slot.
// Optional feature macro: DECODE_WB_BYPASS_EN (forward a same-cycle writeback
// into rd1/rd2 on accept and into a stalled slot).
module decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);
    localparam int unsigned RIDX = (NREGS > 1) ? $clog2(NREGS) : 1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b1000;
    localparam logic [3:0] ALU_PASSB = 4'b1111;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic [4:0] rs1_f;
    logic [4:0] rs2_f;
    logic [4:0] rd_f;

    assign opcode   = bus.instr_i[6:0];
    assign funct3   = bus.instr_i[14:12];
    assign funct7_5 = bus.instr_i[30];
    assign rs1_f    = bus.instr_i[19:15];
    assign rs2_f    = bus.instr_i[24:20];
    assign rd_f     = bus.instr_i[11:7];

    // Immediates, sign-extended from instruction bit 31
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;

    assign imm_i = XLEN'($signed(bus.instr_i[31:20]));
    assign imm_s = XLEN'($signed({bus.instr_i[31:25], bus.instr_i[11:7]}));
    assign imm_b = XLEN'($signed({bus.instr_i[31], bus.instr_i[7], bus.instr_i[30:25],
                                  bus.instr_i[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({bus.instr_i[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({bus.instr_i[31], bus.instr_i[19:12], bus.instr_i[20],
                                  bus.instr_i[30:21], 1'b0}));

    // Slot registers
    logic            out_valid_q,  out_valid_d;
    logic            reg_write_q,  reg_write_d;
    logic [1:0]      result_src_q, result_src_d;
    logic            mem_write_q,  mem_write_d;
    logic            jump_q,       jump_d;
    logic            branch_q,     branch_d;
    logic [3:0]      alu_ctrl_q,   alu_ctrl_d;
    logic            alu_srca_q,   alu_srca_d;
    logic            alu_src_q,    alu_src_d;
    logic [XLEN-1:0] rd1_q,        rd1_d;
    logic [XLEN-1:0] rd2_q,        rd2_d;
    logic [4:0]      rs1_q,        rs1_d;
    logic [4:0]      rs2_q,        rs2_d;
    logic [4:0]      rd_q,         rd_d;
    logic [XLEN-1:0] imm_q,        imm_d;
    logic [XLEN-1:0] pc_q,         pc_d;
    logic [XLEN-1:0] pc_plus4_q,   pc_plus4_d;
    logic            illegal_q,    illegal_d;

    // Handshake
    logic in_ready_c;
    logic accept;
    logic stall;

    assign in_ready_c = !out_valid_q || bus.out_ready;
    assign accept     = bus.in_valid && in_ready_c;
    assign stall      = out_valid_q && !bus.out_ready;

    // Register file; x0 and indices beyond NREGS are never stored
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            wr_en;
    logic            rs1_ok;
    logic            rs2_ok;
    logic [XLEN-1:0] rf_rd1;
    logic [XLEN-1:0] rf_rd2;

    assign wr_en  = bus.wb_we && (bus.wb_rd != 5'd0) && (32'(bus.wb_rd) < NREGS);
    assign rs1_ok = (rs1_f != 5'd0) && (32'(rs1_f) < NREGS);
    assign rs2_ok = (rs2_f != 5'd0) && (32'(rs2_f) < NREGS);
    assign rf_rd1 = rs1_ok ? regs_q[rs1_f[RIDX-1:0]] : '0;
    assign rf_rd2 = rs2_ok ? regs_q[rs2_f[RIDX-1:0]] : '0;

    // Register file next state: single writeback port
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[bus.wb_rd[RIDX-1:0]] = bus.wb_data;
        end
    end

    // Register file storage, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Opcode decode into control signals, immediate and illegal flag
    logic            dec_reg_write;
    logic [1:0]      dec_result_src;
    logic            dec_mem_write;
    logic            dec_jump;
    logic            dec_branch;
    logic [3:0]      dec_alu_ctrl;
    logic            dec_alu_srca;
    logic            dec_alu_src;
    logic [XLEN-1:0] dec_imm;
    logic            dec_illegal;
    logic            use_rd;
    logic            use_rs1;
    logic            use_rs2;

    always_comb begin
        dec_reg_write  = 1'b0;
        dec_result_src = RES_ALU;
        dec_mem_write  = 1'b0;
        dec_jump       = 1'b0;
        dec_branch     = 1'b0;
        dec_alu_ctrl   = ALU_ADD;
        dec_alu_srca   = 1'b0;
        dec_alu_src    = 1'b0;
        dec_imm        = '0;
        dec_illegal    = 1'b0;
        use_rd         = 1'b0;
        use_rs1        = 1'b0;
        use_rs2        = 1'b0;
        case (opcode)
            OPC_LUI: begin
                dec_reg_write = 1'b1;
                dec_alu_ctrl  = ALU_PASSB;
                dec_alu_src   = 1'b1;
                dec_imm       = imm_u;
                use_rd        = 1'b1;
            end
            OPC_AUIPC: begin
                dec_reg_write = 1'b1;
                dec_alu_srca  = 1'b1;
                dec_alu_src   = 1'b1;
                dec_imm       = imm_u;
                use_rd        = 1'b1;
            end
            OPC_JAL: begin
                dec_reg_write  = 1'b1;
                dec_result_src = RES_PC4;
                dec_jump       = 1'b1;
                dec_alu_src    = 1'b1;
                dec_imm        = imm_j;
                use_rd         = 1'b1;
            end
            OPC_JALR: begin
                dec_reg_write  = 1'b1;
                dec_result_src = RES_PC4;
                dec_jump       = 1'b1;
                dec_alu_src    = 1'b1;
                dec_imm        = imm_i;
                use_rd         = 1'b1;
                use_rs1        = 1'b1;
            end
            OPC_BRANCH: begin
                dec_branch   = 1'b1;
                dec_alu_ctrl = ALU_SUB;
                dec_imm      = imm_b;
                use_rs1      = 1'b1;
                use_rs2      = 1'b1;
            end
            OPC_LOAD: begin
                dec_reg_write  = 1'b1;
                dec_result_src = RES_MEM;
                dec_alu_src    = 1'b1;
                dec_imm        = imm_i;
                use_rd         = 1'b1;
                use_rs1        = 1'b1;
            end
            OPC_STORE: begin
                dec_mem_write = 1'b1;
                dec_alu_src   = 1'b1;
                dec_imm       = imm_s;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OPC_OP: begin
                dec_reg_write = 1'b1;
                dec_alu_ctrl  = {funct7_5, funct3};
                use_rd        = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OPC_OPIMM: begin
                dec_reg_write = 1'b1;
                dec_alu_ctrl  = {(funct3 == 3'b101) ? funct7_5 : 1'b0, funct3};
                dec_alu_src   = 1'b1;
                dec_imm       = imm_i;
                use_rd        = 1'b1;
                use_rs1       = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
        // Only register fields the format actually uses can make it illegal
        if ((use_rd  && (32'(rd_f)  >= NREGS)) ||
            (use_rs1 && (32'(rs1_f) >= NREGS)) ||
            (use_rs2 && (32'(rs2_f) >= NREGS))) begin
            dec_illegal = 1'b1;
        end
    end

    // Slot next state: load on accept, hold otherwise, flush clears valid
    always_comb begin
        out_valid_d  = !bus.flush_i && (accept || stall);
        reg_write_d  = reg_write_q;
        result_src_d = result_src_q;
        mem_write_d  = mem_write_q;
        jump_d       = jump_q;
        branch_d     = branch_q;
        alu_ctrl_d   = alu_ctrl_q;
        alu_srca_d   = alu_srca_q;
        alu_src_d    = alu_src_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        rd_d         = rd_q;
        imm_d        = imm_q;
        pc_d         = pc_q;
        pc_plus4_d   = pc_plus4_q;
        illegal_d    = illegal_q;
        if (accept) begin
            reg_write_d  = dec_reg_write;
            result_src_d = dec_result_src;
            mem_write_d  = dec_mem_write;
            jump_d       = dec_jump;
            branch_d     = dec_branch;
            alu_ctrl_d   = dec_alu_ctrl;
            alu_srca_d   = dec_alu_srca;
            alu_src_d    = dec_alu_src;
            rd1_d        = rf_rd1;
            rd2_d        = rf_rd2;
            rs1_d        = rs1_f;
            rs2_d        = rs2_f;
            rd_d         = rd_f;
            imm_d        = dec_imm;
            pc_d         = bus.pc_i;
            pc_plus4_d   = bus.pc_plus4_i;
            illegal_d    = dec_illegal;
        end
`ifdef DECODE_WB_BYPASS_EN
        // Forward only writes that actually land, so x0 and out-of-range stay 0
        if (accept) begin
            if (wr_en && (bus.wb_rd == rs1_f)) rd1_d = bus.wb_data;
            if (wr_en && (bus.wb_rd == rs2_f)) rd2_d = bus.wb_data;
        end else if (stall) begin
            if (wr_en && (bus.wb_rd == rs1_q)) rd1_d = bus.wb_data;
            if (wr_en && (bus.wb_rd == rs2_q)) rd2_d = bus.wb_data;
        end
`endif
    end

    // Slot registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            reg_write_q  <= 1'b0;
            result_src_q <= 2'b00;
            mem_write_q  <= 1'b0;
            jump_q       <= 1'b0;
            branch_q     <= 1'b0;
            alu_ctrl_q   <= 4'b0000;
            alu_srca_q   <= 1'b0;
            alu_src_q    <= 1'b0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            rs1_q        <= 5'd0;
            rs2_q        <= 5'd0;
            rd_q         <= 5'd0;
            imm_q        <= '0;
            pc_q         <= '0;
            pc_plus4_q   <= '0;
            illegal_q    <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            mem_write_q  <= mem_write_d;
            jump_q       <= jump_d;
            branch_q     <= branch_d;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_srca_q   <= alu_srca_d;
            alu_src_q    <= alu_src_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            rd_q         <= rd_d;
            imm_q        <= imm_d;
            pc_q         <= pc_d;
            pc_plus4_q   <= pc_plus4_d;
            illegal_q    <= illegal_d;
        end
    end

    assign bus.in_ready     = in_ready_c;
    assign bus.out_valid    = out_valid_q;
    assign bus.reg_write_o  = reg_write_q;
    assign bus.result_src_o = result_src_q;
    assign bus.mem_write_o  = mem_write_q;
    assign bus.jump_o       = jump_q;
    assign bus.branch_o     = branch_q;
    assign bus.alu_ctrl_o   = alu_ctrl_q;
    assign bus.alu_srca_o   = alu_srca_q;
    assign bus.alu_src_o    = alu_src_q;
    assign bus.rd1_o        = rd1_q;
    assign bus.rd2_o        = rd2_q;
    assign bus.rs1_o        = rs1_q;
    assign bus.rs2_o        = rs2_q;
    assign bus.rd_o         = rd_q;
    assign bus.imm_o        = imm_q;
    assign bus.pc_o         = pc_q;
    assign bus.pc_plus4_o   = pc_plus4_q;
    assign bus.illegal_o    = illegal_q;
endmodule
